// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundles the CPU request port, the DMA request port and the
//            single-port memory bus that mem_port_arbiter sits between.
// Ports    : cpu_*  - CPU requester handshake (req/we/addr/wdata/ack/rdata)
//            dma_*  - DMA requester handshake (same meaning as cpu_*)
//            mem_*  - memory address, write data, strobes and read data
//            busy   - arbiter is serving an access
// Modports : slave  - arbiter view
//            master - requester/memory environment view
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 12
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rden;
  logic          mem_wren;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_addr, mem_wdata, mem_rden, mem_wren,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_addr, mem_wdata, mem_rden, mem_wren,
    output mem_rdata,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between the CPU controller and a
//            cycle-stealing DMA engine. One access at a time is walked through
//            IDLE -> ISSUE -> (WAIT) -> DONE. DMA normally wins a tie, but a
//            streak counter hands the CPU a slot after DMA_MAX_BURST
//            consecutive DMA grants taken while the CPU was waiting.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            bus  - mem_port_arbiter_if.slave (CPU port, DMA port, memory bus,
//                   busy flag)
// Params   : AW, DW         - address / data widths
//            RD_LAT         - cycles after ISSUE until mem_rdata is valid
//            DMA_MAX_BURST  - DMA grants allowed while cpu_req is pending
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW            = 12,
  parameter int DW            = 12,
  parameter int RD_LAT        = 1,
  parameter int DMA_MAX_BURST = 4
) (
  input  wire                clk,
  input  wire                rst,
  mem_port_arbiter_if.slave  bus
);

  // A zero burst limit still needs a 1-bit counter to keep widths legal.
  localparam int SW = (DMA_MAX_BURST > 0) ? $clog2(DMA_MAX_BURST + 1) : 1;
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [SW-1:0] C_BURST_MAX = SW'(DMA_MAX_BURST);
  localparam logic [CW-1:0] C_RD_LAT    = CW'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_owner_dma;
  logic          r_we;
  logic [SW-1:0] r_streak;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_rden;
  logic          r_mem_wren;
  logic          r_cpu_ack;
  logic          r_dma_ack;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dma_rdata;
  logic          r_busy;

  logic          w_dma_wins;
  logic [SW-1:0] w_streak_inc;

  // DMA takes a tie only while its streak is below the limit.
  assign w_dma_wins   = bus.dma_req & (~bus.cpu_req | (r_streak < C_BURST_MAX));
  assign w_streak_inc = (r_streak == C_BURST_MAX) ? r_streak : r_streak + SW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner_dma <= 1'b0;
      r_we        <= 1'b0;
      r_streak    <= '0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_rden  <= 1'b0;
      r_mem_wren  <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      // Strobes and acks are single-cycle pulses; only the transition into
      // ISSUE or DONE raises them.
      r_mem_rden <= 1'b0;
      r_mem_wren <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_dma_ack  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.cpu_req || bus.dma_req) begin
            r_owner_dma <= w_dma_wins;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
            // mem_addr/mem_wdata double as the latched request; they keep
            // their value between accesses.
            if (w_dma_wins) begin
              r_we        <= bus.dma_we;
              r_mem_addr  <= bus.dma_addr;
              r_mem_wdata <= bus.dma_wdata;
              r_mem_wren  <= bus.dma_we;
              r_mem_rden  <= ~bus.dma_we;
              // Only DMA grants that made the CPU wait count toward the limit.
              r_streak    <= bus.cpu_req ? w_streak_inc : '0;
            end else begin
              r_we        <= bus.cpu_we;
              r_mem_addr  <= bus.cpu_addr;
              r_mem_wdata <= bus.cpu_wdata;
              r_mem_wren  <= bus.cpu_we;
              r_mem_rden  <= ~bus.cpu_we;
              r_streak    <= '0;
            end
          end
        end

        S_ISSUE: begin
          if (r_we) begin
            r_state   <= S_DONE;
            r_cpu_ack <= ~r_owner_dma;
            r_dma_ack <= r_owner_dma;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= C_RD_LAT;
          end
        end

        S_WAIT: begin
          // Count 1 marks the cycle in which mem_rdata is valid.
          if (r_cnt == CW'(1)) begin
            if (r_owner_dma) begin
              r_dma_rdata <= bus.mem_rdata;
            end else begin
              r_cpu_rdata <= bus.mem_rdata;
            end
            r_state   <= S_DONE;
            r_cpu_ack <= ~r_owner_dma;
            r_dma_ack <= r_owner_dma;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.dma_ack   = r_dma_ack;
  assign bus.dma_rdata = r_dma_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_rden  = r_mem_rden;
  assign bus.mem_wren  = r_mem_wren;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port main memory between the CPU multicycle controller and a DMA/IO engine.
- Serializes one access at a time through an IDLE/ISSUE/WAIT/DONE state machine.
- DMA is the cycle-stealing requester and normally wins; a starvation counter guarantees the CPU a slot after a bounded DMA burst.
- Sits between the controller's memory address/rden/wren path and the memory instance.

Parameters:
AW, 12, address width
DW, 12, data word width
RD_LAT, 1, cycles after the ISSUE cycle until mem_rdata is valid (>=1)
DMA_MAX_BURST, 4, max consecutive DMA grants while cpu_req is pending (0 = CPU always wins ties)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  DW  CPU read data, valid in the cpu_ack cycle and held until the next CPU read completes
dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same directions, widths and meanings for the DMA port
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rden  out  1  memory read strobe
mem_wren  out  1  memory write strobe
mem_rdata  in  DW  memory read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE and the streak counter to 0. All outputs are 0: acks, strobes, busy, mem_addr, mem_wdata, cpu_rdata, dma_rdata. Outputs stay 0 while rst is high.
- IDLE:
  - If any req is sampled high, pick a winner.
  - Latch owner, we, addr and wdata from the winner, then go to ISSUE.
  - With no request, stay in IDLE.
- Arbitration when both requests are high: DMA wins if streak < DMA_MAX_BURST, otherwise CPU wins. A single request wins unconditionally.
- Streak counter (saturating, width clog2(DMA_MAX_BURST+1)):
  - CPU grant: clear to 0.
  - DMA grant with cpu_req high: increment.
  - DMA grant with cpu_req low: clear to 0.
- ISSUE (exactly 1 cycle):
  - mem_addr and mem_wdata come from the latched values.
  - mem_wren=1 for a write or mem_rden=1 for a read; the strobe is high only in this cycle.
  - Write goes to DONE. Read goes to WAIT with the down-counter loaded to RD_LAT.
- WAIT (RD_LAT cycles): mem_rdata is captured into the owner's rdata register on the last WAIT cycle, then the state goes to DONE.
- DONE (1 cycle): owner's ack=1, then go to IDLE.
- Latency, with the request sampled in IDLE at cycle t:
  - Write: ISSUE at t+1, ack at t+2.
  - Read: ISSUE at t+1, WAIT at t+2..t+1+RD_LAT, ack at t+2+RD_LAT.
  - Back-to-back throughput: one write per 3 cycles, one read per 3+RD_LAT cycles.
- Handshake rules:
  - Requester holds req, we, addr and wdata stable until ack.
  - Requester deasserts req on the edge ending the ack cycle. A req still high in the cycle after ack is a new request.
  - req is not sampled outside IDLE; a request arriving mid-access waits.
  - Non-owner rdata is never modified.
- mem_addr and mem_wdata hold the last latched values between accesses. Strobes are only ever high in ISSUE; both strobes are never high together.
- Reset mid-operation (ISSUE/WAIT/DONE):
  - The access is abandoned; no ack is ever issued for it.
  - On the next cycle state=IDLE, busy=0 and strobes=0.
  - Requesters re-request after reset.

Test Plan:
1. Reset, then DMA read: RD_LAT=1, dma_req at cycle t, addr 0x03C, mem_rdata 0x555 -> mem_rden only at t+1 with mem_addr=0x03C; dma_ack=1 only at t+3 with dma_rdata=0x555; cpu_ack and cpu_rdata stay 0.
2. CPU read: RD_LAT=2, cpu_req at t, addr 0x05A, mem_rdata 0x7FF -> mem_rden only at t+1, cpu_ack only at t+4, cpu_rdata=0x7FF held afterwards; dma_rdata unchanged.
3. CPU write: addr 0x100, wdata 0x123 -> mem_wren=1, mem_addr=0x100, mem_wdata=0x123 only at t+1; cpu_ack at t+2; mem_rden never high.
4. Starvation bound: DMA_MAX_BURST=4, both reqs held high, writes -> grant order D,D,D,D,C,D,D,D,D,C; streak returns to 0 after each CPU grant.
5. DMA-only continuous reads, RD_LAT=1: ack every 4 cycles and streak stays 0. cpu_req raised mid-stream -> CPU granted no later than the 5th grant after it rises.
6. rst pulsed during WAIT of a CPU read -> next cycle busy=0, no cpu_ack, strobes 0, cpu_rdata=0. A fresh cpu_req afterwards is served with normal latency.
